// File: rtl/fp_alu_seq.sv
// Multi-cycle IEEE-754-style floating-point add/sub/mul/div with valid/ready handshakes.
// Define FP_ALU_STICKY_FLAGS_EN to add the sticky_flags/clr_sticky accumulated-flag ports.
`timescale 1ns/1ps
module fp_alu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_operand,
    input  logic [W-1:0] b_operand,
    input  logic [3:0]   operation,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] alu_output,
    output logic         exception,
    output logic         overflow,
    output logic         underflow,
`ifdef FP_ALU_STICKY_FLAGS_EN
    output logic [2:0]   sticky_flags,
    input  logic         clr_sticky,
`endif
    output logic         busy
);
    // Handshake: an operation is accepted on a rising edge with in_valid && in_ready (in_ready is
    // high only in IDLE); a result is consumed on a rising edge with out_valid && out_ready.
    localparam int MW      = MAN_W + 3;
    localparam int RW      = MAN_W + 4;
    localparam int EW      = EXP_W + 2;
    localparam int PW      = 2 * MAN_W + 2;
    localparam int LW      = $clog2(RW);
    localparam int DIV_CYC = MAN_W + 2;
    localparam int CW      = $clog2(DIV_CYC + 1);
    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [3:0] OP_ADD = 4'd10;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd1;
    localparam logic [3:0] OP_DIV = 4'd2;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_EXEC, S_NORM, S_DONE} state_t;
    state_t state;

    logic [W-1:0]           a_q, b_q;
    logic [3:0]             op_q;
    logic                   exc_q, sub_q, sign_q, zero_sign_q;
    logic [MW-1:0]          mx_q, my_q;
    logic [MAN_W:0]         ma_q, mb_q, quo_q;
    logic [MAN_W+2:0]       rem_q;
    logic [CW-1:0]          cnt_q;
    logic signed [EW-1:0]   exp_q;
    logic [RW-1:0]          res_man_q;

    // Unpack and align (ALIGN stage)
    logic                   sa, sb, sb_eff, za, zb, a_big, big_sign, legal, exc_c;
    logic [EXP_W-1:0]       ea, eb, e_big, e_diff;
    logic [MAN_W:0]         ma, mb, m_big, m_small;
    logic [MW-1:0]          small_ext, small_sh, shift_mask;

    always_comb begin
        sa      = a_q[W-1];
        sb      = b_q[W-1];
        ea      = a_q[W-2 -: EXP_W];
        eb      = b_q[W-2 -: EXP_W];
        za      = (ea == '0);
        zb      = (eb == '0);
        ma      = za ? '0 : {1'b1, a_q[MAN_W-1:0]};
        mb      = zb ? '0 : {1'b1, b_q[MAN_W-1:0]};
        sb_eff  = (op_q == OP_SUB) ? ~sb : sb;
        legal   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL) || (op_q == OP_DIV);
        exc_c   = !legal || (&ea) || (&eb) || ((op_q == OP_DIV) && zb);
        // Flushed zeros carry ma == 0, so they always sort as the smaller magnitude.
        a_big    = {ea, ma} >= {eb, mb};
        e_big    = a_big ? ea : eb;
        e_diff   = a_big ? (ea - eb) : (eb - ea);
        m_big    = a_big ? ma : mb;
        m_small  = a_big ? mb : ma;
        big_sign = a_big ? sa : sb_eff;
        small_ext = {m_small, 2'b00};
        if (e_diff >= EXP_W'(MW)) begin
            small_sh   = '0;
            shift_mask = '1;
        end else begin
            small_sh   = small_ext >> e_diff;
            shift_mask = ~({MW{1'b1}} << e_diff);
        end
        small_sh[0] = small_sh[0] | (|(small_ext & shift_mask));
    end

    // Restoring divide step and full-width product (EXEC stage)
    logic [MAN_W+2:0] rem_sub, rem_next;
    logic             q_bit;
    logic [PW-1:0]    prod;

    always_comb begin
        q_bit    = rem_q >= {2'b00, mb_q};
        rem_sub  = rem_q - {2'b00, mb_q};
        rem_next = (q_bit ? rem_sub : rem_q) << 1;
        prod     = {{(MAN_W+1){1'b0}}, ma_q} * {{(MAN_W+1){1'b0}}, mb_q};
    end

    // Normalise, truncate and classify (NORM stage); res_man_q has the unit bit at RW-2.
    logic [LW-1:0]        msb;
    logic [RW-1:0]        nm;
    logic signed [EW-1:0] ne;
    logic [MAN_W-1:0]     frac;
    logic [W-1:0]         res_word;
    logic [2:0]           res_flags;
    logic                 unused_bits;

    always_comb begin
        msb = '0;
        for (int i = 0; i < RW; i++) begin
            if (res_man_q[i]) msb = LW'(i);
        end
        if (res_man_q[RW-1]) begin
            nm = res_man_q >> 1;
            ne = exp_q + EW'(1);
        end else begin
            nm = res_man_q << (LW'(RW-2) - msb);
            ne = exp_q - $signed(EW'(LW'(RW-2) - msb));
        end
        frac = nm[RW-3 -: MAN_W];
        if (exc_q) begin
            res_word  = QNAN;
            res_flags = 3'b100;
        end else if (res_man_q == '0) begin
            res_word  = {zero_sign_q, {(W-1){1'b0}}};
            res_flags = 3'b000;
        end else if (ne >= EXP_MAX) begin
            res_word  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_flags = 3'b010;
        end else if (ne <= EW'(0)) begin
            res_word  = {sign_q, {(W-1){1'b0}}};
            res_flags = 3'b001;
        end else begin
            res_word  = {sign_q, ne[EXP_W-1:0], frac};
            res_flags = 3'b000;
        end
    end

    assign unused_bits = ^{nm[RW-1:RW-2], nm[RW-3-MAN_W:0], ne[EW-1:EXP_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            alu_output  <= '0;
            exception   <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            exc_q       <= 1'b0;
            sub_q       <= 1'b0;
            sign_q      <= 1'b0;
            zero_sign_q <= 1'b0;
            mx_q        <= '0;
            my_q        <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            res_man_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a_operand;
                        b_q      <= b_operand;
                        op_q     <= operation;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    exc_q <= exc_c;
                    ma_q  <= ma;
                    mb_q  <= mb;
                    rem_q <= {2'b00, ma};
                    quo_q <= '0;
                    cnt_q <= '0;
                    mx_q  <= {m_big, 2'b00};
                    my_q  <= small_sh;
                    sub_q <= sa ^ sb_eff;
                    case (op_q)
                        OP_MUL: begin
                            exp_q       <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                            sign_q      <= sa ^ sb;
                            zero_sign_q <= sa ^ sb;
                        end
                        OP_DIV: begin
                            exp_q       <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
                            sign_q      <= sa ^ sb;
                            zero_sign_q <= sa ^ sb;
                        end
                        default: begin
                            exp_q       <= $signed({2'b00, e_big});
                            sign_q      <= big_sign;
                            // Only -0 + -0 keeps a negative zero; cancellation yields +0.
                            zero_sign_q <= sa & sb_eff;
                        end
                    endcase
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_DIV: begin
                            rem_q <= rem_next;
                            quo_q <= {quo_q[MAN_W-1:0], q_bit};
                            cnt_q <= cnt_q + CW'(1);
                            if (cnt_q == CW'(DIV_CYC - 1)) begin
                                res_man_q <= {1'b0, quo_q, q_bit, |rem_next};
                                state     <= S_NORM;
                            end
                        end
                        OP_MUL: begin
                            res_man_q <= prod[PW-1 -: RW] | RW'(|prod[PW-RW-1:0]);
                            state     <= S_NORM;
                        end
                        default: begin
                            res_man_q <= sub_q ? ({1'b0, mx_q} - {1'b0, my_q})
                                               : ({1'b0, mx_q} + {1'b0, my_q});
                            state     <= S_NORM;
                        end
                    endcase
                end
                S_NORM: begin
                    alu_output <= res_word;
                    exception  <= res_flags[2];
                    overflow   <= res_flags[1];
                    underflow  <= res_flags[0];
                    out_valid  <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef FP_ALU_STICKY_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= 3'b000;
        end else if (clr_sticky) begin
            sticky_flags <= 3'b000;
        end else if ((state == S_DONE) && out_ready) begin
            sticky_flags <= sticky_flags | {exception, overflow, underflow};
        end
    end
`endif

endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed, table-driven bench for fp_alu_seq: result/flag/latency vectors plus
// hand-written stall, reset-abort and (optionally) sticky-flag sequences.
`timescale 1ns/1ps
module tb_fp_alu_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic [3:0]  operation;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_output;
    logic        exception;
    logic        overflow;
    logic        underflow;
    logic        busy;
`ifdef FP_ALU_STICKY_FLAGS_EN
    logic [2:0]  sticky_flags;
    logic        clr_sticky;
`endif

    int checks = 0;
    int errors = 0;

    fp_alu_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_operand(a_operand),
        .b_operand(b_operand),
        .operation(operation),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_output(alu_output),
        .exception(exception),
        .overflow(overflow),
        .underflow(underflow),
`ifdef FP_ALU_STICKY_FLAGS_EN
        .sticky_flags(sticky_flags),
        .clr_sticky(clr_sticky),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for out_valid; leaves the result unconsumed.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         output int lat, output int rdy_hi, output int busy_lo);
        int n;
        a_operand = a;
        b_operand = b;
        operation = op;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        a_operand = $urandom;
        b_operand = $urandom;
        operation = 4'($urandom_range(0, 15));
        n = 0;
        rdy_hi = 0;
        busy_lo = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) rdy_hi++;
            if (!busy) busy_lo++;
            tick();
            n++;
        end
        lat = out_valid ? n : -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat, rdy_hi, busy_lo, quiet;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_operand = '0;
        b_operand = '0;
        operation = '0;
`ifdef FP_ALU_STICKY_FLAGS_EN
        clr_sticky = 1'b0;
`endif

        vecs[0]  = '{32'h3FC00000, 32'h40100000, 4'd10, 32'h40700000, 3'b000, 3};
        vecs[1]  = '{32'h40700000, 32'h3FC00000, 4'd3,  32'h40100000, 3'b000, 3};
        vecs[2]  = '{32'h3FC00000, 32'h40000000, 4'd1,  32'h40400000, 3'b000, 3};
        vecs[3]  = '{32'h7F000000, 32'h7F000000, 4'd1,  32'h7F800000, 3'b010, 3};
        vecs[4]  = '{32'h40C00000, 32'h3FC00000, 4'd2,  32'h40800000, 3'b000, 27};
        vecs[5]  = '{32'h3F800000, 32'h00000000, 4'd2,  32'h7FC00000, 3'b100, 27};
        vecs[6]  = '{32'h3F800000, 32'h3F800000, 4'd7,  32'h7FC00000, 3'b100, 0};
        vecs[7]  = '{32'h40490FDB, 32'h00000000, 4'd10, 32'h40490FDB, 3'b000, 3};
        vecs[8]  = '{32'h80000000, 32'h3F800000, 4'd1,  32'h80000000, 3'b000, 3};
        vecs[9]  = '{32'h3F800000, 32'hBF800000, 4'd10, 32'h00000000, 3'b000, 3};
        vecs[10] = '{32'h00800000, 32'h00800000, 4'd1,  32'h00000000, 3'b001, 3};
        vecs[11] = '{32'h7FC00000, 32'h3F800000, 4'd10, 32'h7FC00000, 3'b100, 3};
        vecs[12] = '{32'h3F800000, 32'h40400000, 4'd2,  32'h3EAAAAAA, 3'b000, 27};
        vecs[13] = '{32'h3F800000, 32'h40000000, 4'd3,  32'hBF800000, 3'b000, 3};
        vecs[14] = '{32'hC0C00000, 32'h3FC00000, 4'd2,  32'hC0800000, 3'b000, 27};
        vecs[15] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 4'd10, 32'h7F800000, 3'b010, 3};
        vecs[16] = '{32'h7F800000, 32'h3F800000, 4'd1,  32'h7FC00000, 3'b100, 3};
        vecs[17] = '{32'h00400000, 32'h3F800000, 4'd10, 32'h3F800000, 3'b000, 3};

        // Reset values
        tick();
        tick();
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset flags", 32'({exception, overflow, underflow}), 32'd0);
        check("reset alu_output", alu_output, 32'h0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].op, lat, rdy_hi, busy_lo);
            check($sformatf("v%0d result", i), alu_output, vecs[i].res);
            check($sformatf("v%0d flags", i), 32'({exception, overflow, underflow}), 32'(vecs[i].flags));
            if (vecs[i].lat != 0)
                check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d in_ready while busy", i), 32'(rdy_hi), 32'd0);
            check($sformatf("v%0d busy while busy", i), 32'(busy_lo), 32'd0);
            consume();
            check($sformatf("v%0d in_ready after accept", i), 32'(in_ready), 32'd1);
            check($sformatf("v%0d out_valid after accept", i), 32'(out_valid), 32'd0);
        end

        // Stall in DONE for 5 cycles with junk offered on the input side
        issue(32'h3FC00000, 32'h40000000, 4'd1, lat, rdy_hi, busy_lo);
        check("stall latency", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            in_valid  = 1'b1;
            a_operand = $urandom;
            b_operand = $urandom;
            operation = 4'd10;
            tick();
            check($sformatf("stall%0d result", k), alu_output, 32'h40400000);
            check($sformatf("stall%0d flags", k), 32'({exception, overflow, underflow}), 32'd0);
            check($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consume();
        check("stall release in_ready", 32'(in_ready), 32'd1);
        check("stall release out_valid", 32'(out_valid), 32'd0);

        // Reset ten cycles into a divide: nothing must be delivered for it
        a_operand = 32'h40C00000;
        b_operand = 32'h3FC00000;
        operation = 4'd2;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        repeat (9) tick();
        check("mid-div busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort alu_output", alu_output, 32'h0);
        tick();
        rst_n = 1'b1;
        quiet = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid || !in_ready) quiet++;
        end
        check("abort no result", 32'(quiet), 32'd0);
        issue(32'h3FC00000, 32'h40100000, 4'd10, lat, rdy_hi, busy_lo);
        check("post-reset add result", alu_output, 32'h40700000);
        check("post-reset add latency", 32'(lat), 32'd3);
        consume();

`ifdef FP_ALU_STICKY_FLAGS_EN
        rst_n = 1'b0;
        #2;
        check("sticky reset", 32'(sticky_flags), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(32'h7F000000, 32'h7F000000, 4'd1, lat, rdy_hi, busy_lo);
        consume();
        check("sticky overflow", 32'(sticky_flags), 32'b010);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("sticky clear", 32'(sticky_flags), 32'b000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
